// File: rtl/convolution_3x3.sv
// Serial 3x3 convolution: one signed tap pair per clock, nine taps per window,
// plus a delayed upstream partial sum added into each window result.
module convolution_3x3 #(
    parameter int I_BW      = 19,
    parameter int O_BW      = 19,
    parameter int X_BW      = 8,
    parameter int W_BW      = 8,
    parameter int DFF_BW    = 19,
    parameter int DFF_TIMES = 27
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic signed [X_BW-1:0] i_x,
    input  logic signed [W_BW-1:0] i_w,
    input  logic signed [I_BW-1:0] i_psum,
    output logic signed [O_BW-1:0] o_y
);

    localparam int P_BW = X_BW + W_BW;

    logic        [3:0]        r_cnt;
    logic signed [O_BW-1:0]   r_acc;
    logic signed [O_BW-1:0]   r_y;
    logic signed [P_BW-1:0]   w_prod;
    logic signed [O_BW-1:0]   w_prod_ext;
    logic signed [O_BW-1:0]   w_base;
    logic signed [O_BW-1:0]   w_sum;
    logic signed [O_BW-1:0]   w_psum_d;

    assign w_prod     = i_x * i_w;
    assign w_prod_ext = O_BW'(w_prod);
    // Tap 0 ignores the stale accumulator so every window starts fresh.
    assign w_base     = (r_cnt == 4'd0) ? '0 : r_acc;
    assign w_sum      = w_base + w_prod_ext;

    genvar g;
    generate
        for (g = 0; g < DFF_TIMES; g++) begin : g_dff
            logic signed [DFF_BW-1:0] r_q;
            if (g == 0) begin : g_head
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_q <= '0;
                    end else begin
                        r_q <= DFF_BW'(i_psum);
                    end
                end
            end else begin : g_body
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_q <= '0;
                    end else begin
                        r_q <= g_dff[g-1].r_q;
                    end
                end
            end
        end
    endgenerate

    assign w_psum_d = O_BW'(g_dff[DFF_TIMES-1].r_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_y   <= '0;
        end else if (r_cnt == 4'd8) begin
            r_y   <= w_sum + w_psum_d;
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_y = r_y;

endmodule

// File: tb/tb_convolution_3x3.sv
// Directed bench for convolution_3x3 with a reference model and a queue
// of expected window results.
module tb_convolution_3x3;

    logic               i_clk;
    logic               i_rst_n;
    logic signed [7:0]  i_x;
    logic signed [7:0]  i_w;
    logic signed [18:0] i_psum;
    logic signed [18:0] o_y;

    convolution_3x3 dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_x     (i_x),
        .i_w     (i_w),
        .i_psum  (i_psum),
        .o_y     (o_y)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int                 n_cmp = 0;
    int                 n_err = 0;
    int                 m_tap;
    longint             m_acc;
    logic signed [18:0] m_y;
    int                 psum_hist[$];
    logic signed [18:0] exp_q[$];

    task automatic chk(input string tag, input logic signed [18:0] exp);
        n_cmp++;
        assert (o_y === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, o_y, exp);
        end
    endtask

    task automatic model_reset();
        m_tap = 0;
        m_acc = 0;
        m_y   = '0;
        psum_hist.delete();
        exp_q.delete();
    endtask

    // One tap: drive, model the edge, then compare just after it.
    task automatic tick(input string tag, input int x, input int w,
                        input int p);
        longint pd;
        int     sz;
        i_x    = 8'(x);
        i_w    = 8'(w);
        i_psum = 19'(p);
        @(posedge i_clk);
        psum_hist.push_back(p);
        sz = psum_hist.size();
        pd = (sz > 27) ? longint'(psum_hist[sz-28]) : 0;
        if (m_tap == 0) m_acc = longint'(x * w);
        else m_acc = m_acc + longint'(x * w);
        if (m_tap == 8) begin
            m_y = 19'(m_acc + pd);
            exp_q.push_back(m_y);
            m_tap = 0;
        end else begin
            m_tap++;
        end
        #1;
        if (exp_q.size() > 0) chk(tag, exp_q.pop_front());
        else chk({tag, "_hold"}, m_y);
    endtask

    task automatic do_reset(input int cycles);
        i_rst_n = 1'b0;
        model_reset();
        repeat (cycles) begin
            i_x    = 8'($urandom);
            i_w    = 8'($urandom);
            i_psum = 19'($urandom);
            @(negedge i_clk);
            chk("reset_hold", 19'sd0);
        end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic window(input string tag, input int x, input int w,
                          input int p);
        for (int k = 0; k < 9; k++) tick(tag, x, w, p);
    endtask

    int bx[9] = '{100, 10, 100, 20, 100, 10, 16, 0, 0};
    int bw[9] = '{50, 5, 15, 50, 50, 40, 5, 0, 0};

    initial begin
        i_rst_n = 1'b0;
        i_x = '0;
        i_w = '0;
        i_psum = '0;
        do_reset(4);

        for (int k = 0; k < 9; k++) tick("basic", bx[k], bw[k], 0);
        chk("basic_13030", 19'sd13030);
        for (int k = 0; k < 8; k++) tick("basic_next", 1, 1, 0);
        chk("basic_held", 19'sd13030);

        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_clear", 19'sd0);
        do_reset(2);

        window("signed_m128x127", -128, 127, 0);
        chk("signed_neg", -19'sd146304);
        window("signed_m128xm128", -128, -128, 0);
        chk("signed_pos", 19'sd147456);

        do_reset(2);
        for (int k = 0; k < 4; k++) window("wrap", -128, -128, 200000);
        chk("wrap_value", -19'sd176832);

        do_reset(2);
        window("psum_w1", 1, 1, 1000);
        chk("psum_w1_9", 19'sd9);
        for (int k = 0; k < 3; k++) window("psum_wn", 1, 1, 1000);
        chk("psum_w4_1009", 19'sd1009);

        do_reset(2);
        window("b2b_a", 2, 3, 0);
        chk("b2b_a_54", 19'sd54);
        window("b2b_b", -1, 5, 0);
        chk("b2b_b_m45", -19'sd45);

        for (int k = 0; k < 5; k++) tick("mid_partial", 7, 9, 0);
        do_reset(1);
        window("mid_after", 1, 1, 0);
        chk("mid_9", 19'sd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
